// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file write-back path: result-queue entry
// layout and result-source identifiers.
package rf_wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              vld;
        logic [REG_W-1:0]  rw;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LD   = 2'd2,
        SRC_MD   = 2'd3
    } wb_src_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular queue of pending load/MDU results with per-slot kill and
// parallel destination-register match outputs for hazard queries.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             flush,
    input  logic             push,
    input  wb_entry_t        pushEntry,
    input  logic             pop,
    output wb_entry_t        headEntry,
    output logic [CNT_W-1:0] count,
    input  logic [DEPTH-1:0] kill,
    input  logic [REG_W-1:0] killRw,
    input  logic [REG_W-1:0] queryA,
    input  logic [REG_W-1:0] queryB,
    output logic [DEPTH-1:0] matchK,
    output logic [DEPTH-1:0] matchA,
    output logic [DEPTH-1:0] matchB
);

    logic [PTR_W-1:0] headPtr_reg;
    logic [PTR_W-1:0] tailPtr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             pushOk;
    logic             popOk;
    wb_entry_t        slots [DEPTH];

    assign popOk  = pop && (count_reg != '0);
    assign pushOk = push && (count_reg < CNT_W'(DEPTH));

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rstN || flush) begin
            headPtr_reg <= '0;
            tailPtr_reg <= '0;
            count_reg   <= '0;
        end else begin
            if (pushOk) tailPtr_reg <= tailPtr_reg + PTR_W'(1);
            if (popOk)  headPtr_reg <= headPtr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(pushOk) - CNT_W'(popOk);
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic              vld_reg;
        logic [REG_W-1:0]  rw_reg;
        logic [DATA_W-1:0] data_reg;
        logic              isTail;
        logic              isHead;

        assign isTail = (tailPtr_reg == PTR_W'(gi));
        assign isHead = (headPtr_reg == PTR_W'(gi));

        // Unoccupied slots always hold vld=0; a fresh push outranks a kill.
        always_ff @(posedge clk) begin
            if (!rstN || flush) begin
                vld_reg <= 1'b0;
            end else if (pushOk && isTail) begin
                vld_reg <= pushEntry.vld;
            end else if ((popOk && isHead) || kill[gi]) begin
                vld_reg <= 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (pushOk && isTail) begin
                rw_reg   <= pushEntry.rw;
                data_reg <= pushEntry.data;
            end
        end

        assign slots[gi]  = '{vld: vld_reg, rw: rw_reg, data: data_reg};
        assign matchK[gi] = vld_reg && (rw_reg == killRw);
        assign matchA[gi] = vld_reg && (rw_reg == queryA);
        assign matchB[gi] = vld_reg && (rw_reg == queryB);
    end

    assign headEntry = slots[headPtr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: ALU results bypass straight to the port,
// load/MDU results are queued and drained when the ALU leaves the port idle.
module rf_wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   Flush,
    input  logic                   alu_we,
    input  logic [REG_W-1:0]       alu_rw,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [REG_W-1:0]       ld_rw,
    input  logic [DATA_W-1:0]      ld_data,
    input  logic                   md_valid,
    output logic                   md_ready,
    input  logic [REG_W-1:0]       md_rw,
    input  logic [DATA_W-1:0]      md_data,
    input  logic [REG_W-1:0]       q_ra,
    input  logic [REG_W-1:0]       q_rb,
    output logic                   q_pend_a,
    output logic                   q_pend_b,
    output logic                   WrEn,
    output logic [REG_W-1:0]       Rw,
    output logic [DATA_W-1:0]      busW,
    output logic [$clog2(DEPTH):0] wb_count
);
    import rf_wb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              ready;
    logic              aluWrite;
    logic              push;
    logic              pop;
    wb_src_e           acceptSrc;
    wb_entry_t         pushEntry;
    wb_entry_t         headEntry;
    logic [DEPTH-1:0]  kill;
    logic [DEPTH-1:0]  matchK;
    logic [DEPTH-1:0]  matchA;
    logic [DEPTH-1:0]  matchB;
    logic              wrEn_reg;
    logic [REG_W-1:0]  rw_reg;
    logic [DATA_W-1:0] busW_reg;

    // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot early.
    assign ready    = (wb_count < CNT_W'(DEPTH)) && !Flush;
    assign ld_ready = ready;
    assign md_ready = ready && !ld_valid;
    assign aluWrite = alu_we && (alu_rw != '0);
    assign pop      = !aluWrite && !Flush && (wb_count != '0);
    assign kill     = aluWrite ? matchK : '0;

    always_comb begin
        acceptSrc = SRC_NONE;
        if (ld_valid && ld_ready) begin
            acceptSrc = SRC_LD;
        end else if (md_valid && md_ready) begin
            acceptSrc = SRC_MD;
        end
    end

    // r0 results are acknowledged to the source but never stored.
    always_comb begin
        pushEntry = '0;
        case (acceptSrc)
            SRC_LD:  pushEntry = '{vld: 1'b1, rw: ld_rw, data: ld_data};
            SRC_MD:  pushEntry = '{vld: 1'b1, rw: md_rw, data: md_data};
            default: pushEntry = '0;
        endcase
    end

    assign push = pushEntry.vld && (pushEntry.rw != '0);

    rf_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .rstN      (Rst_n),
        .flush     (Flush),
        .push      (push),
        .pushEntry (pushEntry),
        .pop       (pop),
        .headEntry (headEntry),
        .count     (wb_count),
        .kill      (kill),
        .killRw    (alu_rw),
        .queryA    (q_ra),
        .queryB    (q_rb),
        .matchK    (matchK),
        .matchA    (matchA),
        .matchB    (matchB)
    );

    assign q_pend_a = (|matchA) && (q_ra != '0);
    assign q_pend_b = (|matchB) && (q_rb != '0);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wrEn_reg <= 1'b0;
            rw_reg   <= '0;
            busW_reg <= '0;
        end else if (aluWrite) begin
            wrEn_reg <= 1'b1;
            rw_reg   <= alu_rw;
            busW_reg <= alu_data;
        end else if (pop) begin
            wrEn_reg <= headEntry.vld;
            if (headEntry.vld) begin
                rw_reg   <= headEntry.rw;
                busW_reg <= headEntry.data;
            end
        end else begin
            wrEn_reg <= 1'b0;
        end
    end

    assign WrEn = wrEn_reg;
    assign Rw   = rw_reg;
    assign busW = busW_reg;

endmodule
